// File: rtl/rgbw_frame_sender.sv
// SPI mode-0 master that sends one 8-byte RGBW control frame per start strobe:
// SYNC, lint, colour index, red, green, blue, white, mode, MSB first, one CS window.
module rgbw_frame_sender #(
    parameter int         CLK_DIV  = 2,
    parameter int         GAP_HALF = 2,
    parameter logic [7:0] SYNC     = 8'h55
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] lint,
    input  logic [7:0] color_idx,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic [7:0] white,
    input  logic [7:0] mode,
    output logic       busy,
    output logic       done,
    output logic [3:0] byte_cnt_out,
    output logic       sck,
    output logic       mosi,
    output logic       cs_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_GAP,
        S_TRAIL
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_HALF - 1);

    state_t      r_state, w_state_next;
    logic [7:0]  r_div_cnt, w_div_cnt_next;
    logic [3:0]  r_gap_cnt, w_gap_cnt_next;
    logic [2:0]  r_bit_cnt, w_bit_cnt_next;
    logic [2:0]  r_byte_cnt, w_byte_cnt_next;
    logic [63:0] r_shift, w_shift_next;
    logic        r_sck, w_sck_next;
    logic        r_cs_n, w_cs_n_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic        w_tick;

    assign w_tick = (r_div_cnt == DIV_LAST);

    // The whole frame is snapshotted into one shift register; its MSB is the line.
    assign mosi         = r_shift[63];
    assign sck          = r_sck;
    assign cs_n         = r_cs_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign byte_cnt_out = {1'b0, r_byte_cnt};

    always_comb begin
        // NOTE: every next-value gets a default first, so no path through the case can infer a latch.
        w_state_next    = r_state;
        w_div_cnt_next  = w_tick ? 8'd0 : r_div_cnt + 8'd1;
        w_gap_cnt_next  = r_gap_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_byte_cnt_next = r_byte_cnt;
        w_shift_next    = r_shift;
        w_sck_next      = r_sck;
        w_cs_n_next     = r_cs_n;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_div_cnt_next = 8'd0;
                if (start) begin
                    w_state_next    = S_LEAD;
                    w_shift_next    = {SYNC, lint, color_idx, red, green, blue, white, mode};
                    w_cs_n_next     = 1'b0;
                    w_busy_next     = 1'b1;
                    w_bit_cnt_next  = 3'd0;
                    w_byte_cnt_next = 3'd0;
                    w_gap_cnt_next  = 4'd0;
                end
            end
            S_LEAD: begin
                if (w_tick) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_tick) begin
                    if (!r_sck) begin
                        w_sck_next = 1'b1;
                    end else begin
                        // Falling edge: present the next bit so the receiver samples on the rise.
                        w_sck_next     = 1'b0;
                        w_shift_next   = {r_shift[62:0], 1'b0};
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_byte_cnt == 3'd7) begin
                                w_state_next = S_TRAIL;
                            end else if (GAP_HALF == 0) begin
                                w_byte_cnt_next = r_byte_cnt + 3'd1;
                            end else begin
                                w_state_next   = S_GAP;
                                w_gap_cnt_next = 4'd0;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_state_next    = S_SHIFT;
                        w_byte_cnt_next = r_byte_cnt + 3'd1;
                    end else begin
                        w_gap_cnt_next = r_gap_cnt + 4'd1;
                    end
                end
            end
            S_TRAIL: begin
                if (w_tick) begin
                    w_state_next    = S_IDLE;
                    w_cs_n_next     = 1'b1;
                    w_busy_next     = 1'b0;
                    w_done_next     = 1'b1;
                    w_byte_cnt_next = 3'd0;
                    w_shift_next    = 64'd0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= 8'd0;
            r_gap_cnt  <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 3'd0;
            r_shift    <= 64'd0;
            r_sck      <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_div_cnt  <= w_div_cnt_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_shift    <= w_shift_next;
            r_sck      <= w_sck_next;
            r_cs_n     <= w_cs_n_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

endmodule

// File: tb/tb_rgbw_frame_sender.sv
// Directed bench for rgbw_frame_sender: a default-parameter instance and a
// CLK_DIV=1/GAP_HALF=0/SYNC=AA instance, each watched by a mode-0 SPI slave monitor.
module tb_rgbw_frame_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset  = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] lint = 8'd0, color_idx = 8'd0, red = 8'd0, green = 8'd0;
    logic [7:0] blue = 8'd0, white = 8'd0, mode = 8'd0;

    logic       busy0, done0, sck0, mosi0, cs_n0;
    logic [3:0] byte_cnt_out0;
    logic       busy1, done1, sck1, mosi1, cs_n1;
    logic [3:0] byte_cnt_out1;

    rgbw_frame_sender dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .lint(lint), .color_idx(color_idx), .red(red), .green(green),
        .blue(blue), .white(white), .mode(mode),
        .busy(busy0), .done(done0), .byte_cnt_out(byte_cnt_out0),
        .sck(sck0), .mosi(mosi0), .cs_n(cs_n0)
    );

    rgbw_frame_sender #(.CLK_DIV(1), .GAP_HALF(0), .SYNC(8'hAA)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .lint(lint), .color_idx(color_idx), .red(red), .green(green),
        .blue(blue), .white(white), .mode(mode),
        .busy(busy1), .done(done1), .byte_cnt_out(byte_cnt_out1),
        .sck(sck1), .mosi(mosi1), .cs_n(cs_n1)
    );

    // Slave monitor for dut0: sampled on the falling clk edge.
    logic       p_sck0 = 1'b0, p_cs0 = 1'b1, p_mosi0 = 1'b0;
    logic [7:0] sh0 = 8'd0;
    int         bits0 = 0, rise0 = 0, dcnt0 = 0, viol0 = 0, lowc0 = 0, highc0 = 0;
    logic [7:0] bq0[$];
    int         lq0[$];
    int         gq0[$];

    always @(negedge clk) begin
        if (sck0 && !p_sck0) begin
            rise0 <= rise0 + 1;
            sh0   <= {sh0[6:0], mosi0};
            if (bits0 == 7) begin
                bq0.push_back({sh0[6:0], mosi0});
                bits0 <= 0;
            end else begin
                bits0 <= bits0 + 1;
            end
        end
        if (cs_n0) bits0 <= 0;
        if (sck0 && p_sck0 && (mosi0 != p_mosi0)) viol0 <= viol0 + 1;
        if (cs_n0 && !p_cs0) begin
            lq0.push_back(lowc0);
            lowc0 <= 0;
        end else if (!cs_n0) begin
            lowc0 <= lowc0 + 1;
        end
        if (!cs_n0 && p_cs0) begin
            gq0.push_back(highc0);
            highc0 <= 0;
        end else if (cs_n0) begin
            highc0 <= highc0 + 1;
        end
        if (done0) dcnt0 <= dcnt0 + 1;
        p_sck0  <= sck0;
        p_cs0   <= cs_n0;
        p_mosi0 <= mosi0;
    end

    // Slave monitor for dut1, plus a trace of byte_cnt_out changes.
    logic       p_sck1 = 1'b0, p_cs1 = 1'b1;
    logic [3:0] p_bc1 = 4'd0;
    logic [7:0] sh1 = 8'd0;
    int         bits1 = 0, rise1 = 0, dcnt1 = 0, lowc1 = 0;
    logic [7:0] bq1[$];
    int         lq1[$];
    logic [3:0] bcq1[$];

    always @(negedge clk) begin
        if (sck1 && !p_sck1) begin
            rise1 <= rise1 + 1;
            sh1   <= {sh1[6:0], mosi1};
            if (bits1 == 7) begin
                bq1.push_back({sh1[6:0], mosi1});
                bits1 <= 0;
            end else begin
                bits1 <= bits1 + 1;
            end
        end
        if (cs_n1) bits1 <= 0;
        if (cs_n1 && !p_cs1) begin
            lq1.push_back(lowc1);
            lowc1 <= 0;
        end else if (!cs_n1) begin
            lowc1 <= lowc1 + 1;
        end
        if (byte_cnt_out1 != p_bc1) bcq1.push_back(byte_cnt_out1);
        if (done1) dcnt1 <= dcnt1 + 1;
        p_sck1 <= sck1;
        p_cs1  <= cs_n1;
        p_bc1  <= byte_cnt_out1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input logic [55:0] f);
        {lint, color_idx, red, green, blue, white, mode} = f;
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0) ? done0 : done1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input int which, input int base, input logic [63:0] exp, input string tag);
        logic [7:0] got;
        for (int i = 0; i < 8; i++) begin
            got = 8'hXX;
            if (which == 0) begin
                if (base + i < bq0.size()) got = bq0[base + i];
            end else begin
                if (base + i < bq1.size()) got = bq1[base + i];
            end
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[63 - 8*i -: 8]});
        end
    endtask

    initial begin
        bit ok;
        int b, r, d, l, g, bc;

        repeat (3) @(negedge clk);
        check("reset_dut0", {23'd0, sck0, mosi0, cs_n0, busy0, done0, byte_cnt_out0}, 32'b001000000);
        check("reset_dut1", {23'd0, sck1, mosi1, cs_n1, busy1, done1, byte_cnt_out1}, 32'b001000000);
        reset = 1'b0;

        // Frame with default parameters.
        set_fields(56'h11223344556677);
        repeat (2) @(negedge clk); #1;
        b = bq0.size(); r = rise0; d = dcnt0; l = lq0.size();
        pulse(0);
        @(negedge clk);
        check("t1_first_cycle", {29'd0, cs_n0, busy0, mosi0}, 32'b010);
        wait_done(0, 600, ok);
        check("t1_done_seen", ok, 1);
        check("t1_done_state", {27'd0, cs_n0, busy0, sck0, mosi0, 1'b0} | {28'd0, byte_cnt_out0}, 32'b10000);
        repeat (2) @(negedge clk); #1;
        check_frame(0, b, 64'h5511223344556677, "t1");
        check("t1_cs_low_len", (l < lq0.size()) ? lq0[l] : -1, 288);
        check("t1_done_count", dcnt0 - d, 1);
        check("t1_sck_rises", rise0 - r, 64);
        check("t1_mosi_stable", viol0, 0);

        // Field changes and repeated starts during a frame are ignored.
        b = bq0.size(); d = dcnt0;
        pulse(0);
        set_fields(56'hFFFFFFFFFFFFFF);
        for (int k = 0; k < 5; k++) begin
            repeat (40) @(posedge clk);
            pulse(0);
        end
        wait_done(0, 200, ok);
        check("t2_done_seen", ok, 1);
        repeat (30) @(negedge clk); #1;
        check("t2_idle_after", {30'd0, cs_n0, busy0}, 32'b10);
        check_frame(0, b, 64'h5511223344556677, "t2");
        check("t2_byte_count", bq0.size() - b, 8);
        check("t2_done_count", dcnt0 - d, 1);

        // Reset in the middle of byte 3, bit 4 aborts the frame at once.
        set_fields(56'h11223344556677);
        r = rise0;
        pulse(0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (rise0 - r >= 28) break;
        end
        check("t3_abort_point", rise0 - r, 28);
        check("t3_pre_reset", {27'd0, busy0, byte_cnt_out0}, 32'b10011);
        d = dcnt0;
        reset = 1'b1;
        #1;
        check("t3_abort_outputs", {27'd0, cs_n0, sck0, mosi0, busy0, done0}, 32'b10000);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk); #1;
        check("t3_no_done", dcnt0 - d, 0);
        b = bq0.size();
        pulse(0);
        wait_done(0, 600, ok);
        check("t3_done_seen", ok, 1);
        repeat (2) @(negedge clk); #1;
        check_frame(0, b, 64'h5511223344556677, "t3");

        // Start in the done cycle: back-to-back frames with a one-cycle CS high gap.
        set_fields(56'h11223344556677);
        repeat (2) @(negedge clk); #1;
        b = bq0.size(); g = gq0.size(); l = lq0.size();
        pulse(0);
        wait_done(0, 600, ok);
        check("t4_done_a", ok, 1);
        start0 = 1'b1;
        set_fields(56'hA1B2C3D4E5F607);
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done(0, 600, ok);
        check("t4_done_b", ok, 1);
        repeat (2) @(negedge clk); #1;
        check_frame(0, b, 64'h5511223344556677, "t4a");
        check_frame(0, b + 8, 64'h55A1B2C3D4E5F607, "t4b");
        check("t4_cs_gap", (g + 1 < gq0.size()) ? gq0[g + 1] : -1, 1);
        check("t4_len_b", (l + 1 < lq0.size()) ? lq0[l + 1] : -1, 288);

        // CLK_DIV=1, GAP_HALF=0, SYNC=AA: contiguous 130-cycle frame.
        set_fields(56'h0000000000A55A);
        repeat (2) @(negedge clk); #1;
        b = bq1.size(); r = rise1; d = dcnt1; l = lq1.size();
        pulse(1);
        @(negedge clk);
        check("t5_first_cycle", {29'd0, cs_n1, busy1, mosi1}, 32'b011);
        wait_done(1, 300, ok);
        check("t5_done_seen", ok, 1);
        check("t5_done_bytecnt", {28'd0, byte_cnt_out1}, 0);
        repeat (2) @(negedge clk); #1;
        check_frame(1, b, 64'hAA0000000000A55A, "t5");
        check("t5_cs_low_len", (l < lq1.size()) ? lq1[l] : -1, 130);
        check("t5_sck_rises", rise1 - r, 64);
        check("t5_done_count", dcnt1 - d, 1);

        // SYNC byte alone with zero fields; byte_cnt_out walks 1..7 then back to 0.
        set_fields(56'h0);
        repeat (2) @(negedge clk); #1;
        b = bq1.size(); bc = bcq1.size();
        pulse(1);
        wait_done(1, 300, ok);
        check("t6_done_seen", ok, 1);
        repeat (2) @(negedge clk); #1;
        check_frame(1, b, 64'hAA00000000000000, "t6");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6_bytecnt_step%0d", i),
                  (bc + i < bcq1.size()) ? {28'd0, bcq1[bc + i]} : 32'hFFFF,
                  (i < 7) ? i + 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgbw_frame_sender.md
Name: rgbw_frame_sender

Overview:
SPI-master transmitter for the RGBW control frame consumed by the controller's SPI receive/dispense path. On a start strobe it snapshots the seven colour/mode fields, then emits one 8-byte frame: SYNC byte, lint, colour index, red, green, blue, white, mode. SPI mode 0, MSB first, one chip-select window per frame. Used as the stimulus/host side on the FPGA bring-up board and for loopback into the receiver.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period (legal range 1..255)
GAP_HALF, 2, idle SCK half-periods inserted between bytes with CS held low (legal range 0..15)
SYNC, 8'h55, value of byte 0

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to send a frame; honoured only when idle
lint  input  8  byte 1
color_idx  input  8  byte 2
red  input  8  byte 3
green  input  8  byte 4
blue  input  8  byte 5
white  input  8  byte 6
mode  input  8  byte 7
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse in the cycle cs_n returns high
byte_cnt_out  output  4  index (0..7) of the byte being shifted; 0 when idle
sck  output  1  SPI clock, idles low
mosi  output  1  SPI data, MSB first
cs_n  output  1  chip select, active low

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). No other clock or enable.
- Reset (asynchronous assert, synchronous release): sck=0, mosi=0, cs_n=1, busy=0, done=0, byte_cnt_out=0, state IDLE, all counters 0. Asserting reset mid-frame aborts the frame immediately. No done pulse is generated for the aborted frame.
- Half-period tick: counter runs 0..CLK_DIV-1 in every non-IDLE state. tick = (count == CLK_DIV-1). The counter restarts at 0 on each state entry.
- Accepted start is start=1 while in IDLE, at cycle T. At T the block latches SYNC and the seven fields into shadow registers. Fields may change freely afterwards without affecting the frame. start while busy is ignored and is not queued.
- State machine:
  - IDLE: on an accepted start, go to LEAD. At T+1: cs_n=0, busy=1, mosi=shadow byte0 bit7.
  - LEAD: one half-period with sck=0, then go to SHIFT.
  - SHIFT: each bit is one low half-period followed by one high half-period.
    - sck rises on a tick at the end of the low half.
    - sck falls on a tick at the end of the high half. mosi advances to the next bit in the same cycle sck falls, so the receiver samples on the rising edge.
    - After bit0 of a byte falls: if byte_cnt < 7 and GAP_HALF > 0, go to GAP. If byte_cnt < 7 and GAP_HALF = 0, increment byte_cnt and continue in SHIFT. If byte_cnt = 7, go to TRAIL.
  - GAP: GAP_HALF half-periods with sck=0 and cs_n=0. On exit, byte_cnt increments and mosi = bit7 of the next byte.
  - TRAIL: one half-period with sck=0. At the end: cs_n=1, busy=0, done=1 for one cycle, mosi=0, byte_cnt=0, go to IDLE.
- Frame length from cs_n falling to cs_n rising: CLK_DIV*(2 + 128 + 7*GAP_HALF) cycles. With defaults this is 2*(2+128+14) = 288 cycles.
- mosi is stable for the full high half-period of every SCK pulse. Exactly 64 rising SCK edges per frame.
- A start asserted in the same cycle as done is accepted, because the state is IDLE in that cycle. The new frame's cs_n then falls on the following cycle, giving at least one full cycle of cs_n=1 between frames.
- byte_cnt_out is a 4-bit counter that never exceeds 7 and never wraps.

Test Plan:
- Default parameters, fields lint=0x11, color_idx=0x22, red=0x33, green=0x44, blue=0x55, white=0x66, mode=0x77, one start pulse -> bench SPI slave (mode 0) captures 55 11 22 33 44 55 66 77. cs_n low exactly 288 cycles. One done pulse. 64 SCK rising edges.
- Change all fields to 0xFF and pulse start repeatedly during the frame -> captured frame is unchanged. Only one frame is sent and only one done pulse occurs.
- Assert reset at byte 3, bit 4 -> cs_n=1, sck=0, mosi=0, busy=0 in the same cycle. No done pulse. A start after release sends a complete, correct frame.
- Pulse start in the same cycle as done -> second frame begins with cs_n high for exactly 1 cycle between frames. Both frames are captured correctly.
- CLK_DIV=1, GAP_HALF=0 -> frame length 130 cycles. Bytes are contiguous. Capture is correct with white=0xA5, mode=0x5A.
- SYNC=8'hAA, all fields 0x00 -> byte 0 is captured as AA. byte_cnt_out steps 0..7 and returns to 0 with done.
